// File: rtl/video_render_zx.sv
// video_render_zx
// Pixel source for the scan-doubler/sync stage. It fetches ZX Spectrum
// screen bytes (bitmap + attribute) from the DRAM arbiter, buffers them in a
// two-group prefetch FIFO, and serialises one 6-bit colour per video cycle.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   cend              7 MHz video-cycle strobe (one clk wide)
//   line_start        start-of-line pulse from the sync stage
//   vpix              high on the 192 lines that carry pixels
//   int_start         once-per-frame pulse, advances the flash counter
//   border_color      port-FE border colour {G,R,B}
//   fetch_req/addr    read request to the arbiter (screen-relative address)
//   fetch_ack/data    request accepted, read data valid in the same cycle
//   pixel, border     colour outputs {r[1:0],g[1:0],b[1:0]}
//   underrun          pulse when a group load finds the FIFO empty
module video_render_zx #(
   parameter int PIX_DELAY = 52
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cend,
   input  logic        line_start,
   input  logic        vpix,
   input  logic        int_start,
   input  logic [2:0]  border_color,
   output logic        fetch_req,
   output logic [12:0] fetch_addr,
   input  logic        fetch_ack,
   input  logic [7:0]  fetch_data,
   output logic [5:0]  pixel,
   output logic [5:0]  border,
   output logic        underrun
);

   typedef enum logic [1:0] {IDLE, REQ_BMP, REQ_ATR, PUSH} state_t;

   localparam logic [8:0] FIRST_CEND = 9'(PIX_DELAY);
   localparam logic [8:0] LAST_CEND  = 9'(PIX_DELAY + 255);
   localparam logic [2:0] FIRST_LO   = FIRST_CEND[2:0];

   // Maps a {G,R,B} colour onto the {r,g,b} 2-bit-per-channel output format.
   function automatic logic [5:0] map_colour(input logic [2:0] grb, input logic bright);
      logic [1:0] lvl;
      lvl = bright ? 2'b11 : 2'b10;
      return {grb[1] ? lvl : 2'b00, grb[2] ? lvl : 2'b00, grb[0] ? lvl : 2'b00};
   endfunction

   function automatic logic [5:0] pix_colour(input logic bit_v, input logic [7:0] attr,
                                             input logic flash_on);
      logic [2:0] ink;
      logic [2:0] paper;
      ink   = attr[2:0];
      paper = attr[5:3];
      if (attr[7] && flash_on) begin
         ink   = attr[5:3];
         paper = attr[2:0];
      end
      return map_colour(bit_v ? ink : paper, attr[6]);
   endfunction

   // ---------------------------------------------------------------- fetch
   state_t      state_q;
   logic        req_q;
   logic [12:0] addr_q;
   logic [4:0]  x_q;
   logic [7:0]  y_q;
   logic        act_q;      // line fetch in progress, fewer than 32 groups pushed
   logic [7:0]  bmp_q;
   logic [7:0]  atr_q;

   logic [4:0]  x_inc;
   logic [12:0] bmp_addr;
   logic [12:0] bmp_addr_next;
   logic [12:0] atr_addr;

   assign x_inc         = x_q + 5'd1;
   assign bmp_addr      = {y_q[7:6], y_q[2:0], y_q[5:3], x_q};
   assign bmp_addr_next = {y_q[7:6], y_q[2:0], y_q[5:3], x_inc};
   assign atr_addr      = {3'b110, y_q[7:3], x_q};

   // ---------------------------------------------------------------- FIFO
   logic [15:0] fifo_mem_q [2];
   logic        wr_ptr_q;
   logic        rd_ptr_q;
   logic [1:0]  count_q;
   logic        fifo_empty;
   logic        fifo_full;
   logic [15:0] fifo_dout;
   logic        push;
   logic        pop;

   assign fifo_empty = (count_q == 2'd0);
   assign fifo_full  = (count_q == 2'd2);
   assign fifo_dout  = fifo_mem_q[rd_ptr_q];

   // --------------------------------------------------------------- shifter
   logic [8:0]  cnt_q;
   logic        shf_act_q;
   logic [7:0]  shift_q;
   logic [7:0]  attr_q;
   logic [5:0]  pixel_q;
   logic        underrun_q;
   logic [5:0]  border_q;
   logic [4:0]  flash_q;

   logic [8:0]  cnt_n;
   logic [2:0]  phase_lo;
   logic        in_win;
   logic        load;
   logic [7:0]  load_bmp;
   logic [7:0]  load_atr;

   assign cnt_n    = cnt_q + 9'd1;
   assign phase_lo = cnt_n[2:0] - FIRST_LO;
   assign in_win   = shf_act_q && (cnt_n >= FIRST_CEND);
   assign load     = in_win && (phase_lo == 3'd0);
   assign load_bmp = fifo_empty ? 8'h00 : fifo_dout[7:0];
   assign load_atr = fifo_empty ? 8'h00 : fifo_dout[15:8];

   // A push may share the cycle with a pop when full: the pop frees the slot.
   assign pop  = cend && !line_start && load && !fifo_empty;
   assign push = (state_q == PUSH) && !line_start && (!fifo_full || pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         addr_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         act_q   <= 1'b0;
         bmp_q   <= '0;
         atr_q   <= '0;
      end else if (line_start) begin
         // A new line always restarts the fetch, abandoning any open request.
         x_q <= '0;
         if (vpix) begin
            state_q <= REQ_BMP;
            req_q   <= 1'b1;
            addr_q  <= {y_q[7:6], y_q[2:0], y_q[5:3], 5'd0};
            act_q   <= 1'b1;
         end else begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            y_q     <= '0;
            act_q   <= 1'b0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (act_q && !fifo_full) begin
                  state_q <= REQ_BMP;
                  req_q   <= 1'b1;
                  addr_q  <= bmp_addr;
               end
            end
            REQ_BMP: begin
               if (fetch_ack) begin
                  bmp_q   <= fetch_data;
                  addr_q  <= atr_addr;
                  state_q <= REQ_ATR;
               end
            end
            REQ_ATR: begin
               if (fetch_ack) begin
                  atr_q   <= fetch_data;
                  req_q   <= 1'b0;
                  state_q <= PUSH;
               end
            end
            PUSH: begin
               if (push) begin
                  x_q <= x_inc;
                  if (x_q == 5'd31) begin
                     state_q <= IDLE;
                     act_q   <= 1'b0;
                     y_q     <= (y_q == 8'd191) ? y_q : y_q + 8'd1;
                  end else begin
                     state_q <= REQ_BMP;
                     req_q   <= 1'b1;
                     addr_q  <= bmp_addr_next;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= {atr_q, bmp_q};
      end
   end

   always_ff @(posedge clk) begin
      if (rst || line_start) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   // Pixel counting starts at the first cend after line_start; the window
   // covers cend numbers FIRST_CEND..LAST_CEND, loading every 8th one.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         shf_act_q  <= 1'b0;
         shift_q    <= '0;
         attr_q     <= '0;
         pixel_q    <= '0;
         underrun_q <= 1'b0;
      end else begin
         underrun_q <= 1'b0;
         if (line_start) begin
            cnt_q     <= '0;
            shf_act_q <= vpix;
         end else if (cend) begin
            if (in_win) begin
               cnt_q <= cnt_n;
               if (load) begin
                  shift_q    <= {load_bmp[6:0], 1'b0};
                  attr_q     <= load_atr;
                  pixel_q    <= pix_colour(load_bmp[7], load_atr, flash_q[4]);
                  underrun_q <= fifo_empty;
               end else begin
                  shift_q <= {shift_q[6:0], 1'b0};
                  pixel_q <= pix_colour(shift_q[7], attr_q, flash_q[4]);
               end
               if (cnt_n == LAST_CEND) shf_act_q <= 1'b0;
            end else begin
               pixel_q <= '0;
               if (shf_act_q) cnt_q <= cnt_n;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         border_q <= '0;
         flash_q  <= '0;
      end else begin
         border_q <= map_colour(border_color, 1'b0);
         if (int_start) flash_q <= flash_q + 5'd1;
      end
   end

   assign fetch_req  = req_q;
   assign fetch_addr = addr_q;
   assign pixel      = pixel_q;
   assign border     = border_q;
   assign underrun   = underrun_q;

endmodule

// File: tb/tb_video_render_zx.sv
// tb_video_render_zx
// Directed bench for video_render_zx: reset, border, pixel decode, line
// addressing, non-pixel lines, flash and FIFO underrun. One video cycle is
// two clk periods (cend high for one of them).
module tb_video_render_zx;

   logic        clk;
   logic        rst;
   logic        cend;
   logic        line_start;
   logic        vpix;
   logic        int_start;
   logic [2:0]  border_color;
   logic        fetch_req;
   logic [12:0] fetch_addr;
   logic        fetch_ack;
   logic [7:0]  fetch_data;
   logic [5:0]  pixel;
   logic [5:0]  border;
   logic        underrun;

   logic        ack_en;
   logic [7:0]  bmp_val;
   logic [7:0]  atr_val;
   logic        req_seen;
   logic [5:0]  pix_s;
   logic        ur_s;
   logic [12:0] addr_log[$];
   int          n_checks;
   int          n_pass;

   video_render_zx #(.PIX_DELAY(52)) dut (
      .clk          (clk),
      .rst          (rst),
      .cend         (cend),
      .line_start   (line_start),
      .vpix         (vpix),
      .int_start    (int_start),
      .border_color (border_color),
      .fetch_req    (fetch_req),
      .fetch_addr   (fetch_addr),
      .fetch_ack    (fetch_ack),
      .fetch_data   (fetch_data),
      .pixel        (pixel),
      .border       (border),
      .underrun     (underrun)
   );

   // Arbiter model: zero-wait when enabled; attribute area is 0x1800 and up.
   assign fetch_ack  = ack_en;
   assign fetch_data = (fetch_addr[12:11] == 2'b11) ? atr_val : bmp_val;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic clk_step();
      @(posedge clk);
      #1;
      if (fetch_req) req_seen = 1'b1;
      if (fetch_req && fetch_ack) addr_log.push_back(fetch_addr);
   endtask

   task automatic cend_step();
      cend = 1'b1;
      clk_step();
      pix_s = pixel;
      ur_s  = underrun;
      cend = 1'b0;
      clk_step();
   endtask

   task automatic start_line(input logic v);
      addr_log.delete();
      line_start = 1'b1;
      vpix       = v;
      clk_step();
      line_start = 1'b0;
   endtask

   task automatic run_cends(input int n);
      repeat (n) cend_step();
   endtask

   task automatic int_pulse(input int n);
      repeat (n) begin
         int_start = 1'b1;
         clk_step();
         int_start = 1'b0;
      end
   endtask

   initial begin
      int p;
      logic [5:0] exp_pix;
      n_checks = 0;
      n_pass   = 0;
      rst = 1'b1; cend = 1'b0; line_start = 1'b0; vpix = 1'b0; int_start = 1'b0;
      border_color = 3'b101; ack_en = 1'b0; bmp_val = 8'h81; atr_val = 8'h47;
      req_seen = 1'b0; pix_s = '0; ur_s = 1'b0;

      // Reset state
      repeat (3) clk_step();
      check_eq("rst_pixel", {10'd0, pixel}, 16'h0000);
      check_eq("rst_border", {10'd0, border}, 16'h0000);
      check_eq("rst_req", {15'd0, fetch_req}, 16'h0000);
      check_eq("rst_addr", {3'd0, fetch_addr}, 16'h0000);
      check_eq("rst_underrun", {15'd0, underrun}, 16'h0000);
      rst = 1'b0;
      clk_step();
      check_eq("border_101", {10'd0, border}, 16'h000A);
      border_color = 3'b010;
      clk_step();
      check_eq("border_010", {10'd0, border}, 16'h0020);

      // Mid-fetch reset with the arbiter stalled
      start_line(1'b1);
      check_eq("stall_req", {15'd0, fetch_req}, 16'h0001);
      check_eq("stall_addr", {3'd0, fetch_addr}, 16'h0000);
      repeat (3) clk_step();
      check_eq("hold_req", {15'd0, fetch_req}, 16'h0001);
      rst = 1'b1;
      clk_step();
      check_eq("midrst_req", {15'd0, fetch_req}, 16'h0000);
      check_eq("midrst_border", {10'd0, border}, 16'h0000);
      repeat (2) clk_step();
      rst = 1'b0;
      repeat (5) clk_step();
      check_eq("postrst_req", {15'd0, fetch_req}, 16'h0000);

      // Pixel decode, y=0: 81/47 gives 3F,00x6,3F per group from cend 52
      ack_en = 1'b1;
      start_line(1'b1);
      check_eq("addr_y0", {3'd0, fetch_addr}, 16'h0000);
      for (int c = 1; c <= 320; c++) begin
         cend_step();
         exp_pix = 6'h00;
         if (c >= 52 && c < 308) begin
            p = (c - 52) % 8;
            if (p == 0 || p == 7) exp_pix = 6'h3F;
         end
         check_eq($sformatf("pix_c%0d", c), {10'd0, pix_s}, {10'd0, exp_pix});
         if (c == 52) check_eq("no_underrun_c52", {15'd0, ur_s}, 16'h0000);
      end

      start_line(1'b1);
      check_eq("addr_y1", {3'd0, fetch_addr}, 16'h0100);
      run_cends(310);

      // Non-pixel lines: no fetches, and y returns to 0
      req_seen = 1'b0;
      start_line(1'b0);
      run_cends(20);
      start_line(1'b0);
      run_cends(10);
      check_eq("blank_no_req", {15'd0, req_seen}, 16'h0000);

      for (int l = 0; l <= 64; l++) begin
         start_line(1'b1);
         if (l == 0)  check_eq("addr_y0_after_blank", {3'd0, fetch_addr}, 16'h0000);
         if (l == 8)  check_eq("addr_y8", {3'd0, fetch_addr}, 16'h0020);
         if (l == 64) check_eq("addr_y64", {3'd0, fetch_addr}, 16'h0800);
         run_cends(310);
         if (l == 8) begin
            check_eq("y8_fetch_count", 16'(addr_log.size()), 16'd64);
            if (addr_log.size() >= 8) begin
               check_eq("bmp_y8_x3", {3'd0, addr_log[6]}, 16'h0023);
               check_eq("atr_y8_x3", {3'd0, addr_log[7]}, 16'h1823);
            end
         end
      end

      // Flash: 87/FF is ink 7 non-bright, swapped to paper 0 when flash_cnt[4]
      bmp_val = 8'hFF;
      atr_val = 8'h87;
      start_line(1'b1);
      run_cends(52);
      check_eq("flash_f0", {10'd0, pix_s}, 16'h002A);
      int_pulse(15);
      start_line(1'b1);
      run_cends(52);
      check_eq("flash_f15", {10'd0, pix_s}, 16'h002A);
      int_pulse(1);
      start_line(1'b1);
      run_cends(52);
      check_eq("flash_f16", {10'd0, pix_s}, 16'h0000);
      int_pulse(15);
      start_line(1'b1);
      run_cends(52);
      check_eq("flash_f31", {10'd0, pix_s}, 16'h0000);
      int_pulse(1);
      start_line(1'b1);
      run_cends(52);
      check_eq("flash_f32", {10'd0, pix_s}, 16'h002A);

      // Underrun: ack withheld for 80 cends, then released
      bmp_val = 8'h81;
      atr_val = 8'h47;
      ack_en  = 1'b0;
      start_line(1'b1);
      for (int c = 1; c <= 91; c++) begin
         cend_step();
         if (c == 51) check_eq("ur_c51", {15'd0, ur_s}, 16'h0000);
         if (c == 52) begin
            check_eq("ur_c52", {15'd0, ur_s}, 16'h0001);
            check_eq("ur_pix_c52", {10'd0, pix_s}, 16'h0000);
         end
         if (c == 53) check_eq("ur_pix_c53", {10'd0, pix_s}, 16'h0000);
         if (c == 59) check_eq("ur_pix_c59", {10'd0, pix_s}, 16'h0000);
         if (c == 60) begin
            check_eq("ur_c60", {15'd0, ur_s}, 16'h0001);
            check_eq("ur_pix_c60", {10'd0, pix_s}, 16'h0000);
         end
         if (c == 80) ack_en = 1'b1;
         if (c == 84) begin
            check_eq("rec_ur_c84", {15'd0, ur_s}, 16'h0000);
            check_eq("rec_pix_c84", {10'd0, pix_s}, 16'h003F);
         end
         if (c == 85) check_eq("rec_pix_c85", {10'd0, pix_s}, 16'h0000);
         if (c == 91) check_eq("rec_pix_c91", {10'd0, pix_s}, 16'h003F);
      end

      // Reset while a pixel is being shown
      rst = 1'b1;
      clk_step();
      check_eq("rst_live_pixel", {10'd0, pixel}, 16'h0000);
      check_eq("rst_live_req", {15'd0, fetch_req}, 16'h0000);
      check_eq("rst_live_underrun", {15'd0, underrun}, 16'h0000);
      rst = 1'b0;
      clk_step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
